// File: rtl/rx_char_restore.sv
// RX character restore: strips |I|/|A|, turns |S| back into an SOF strobe, and
// checks the x1 lane-0 SOF sequence. Optional |A| interval monitor: RX_AM_MON_EN.
module rx_char_restore #(
  parameter int unsigned AM_INTERVAL = 64,
  parameter logic [31:0] SOF_DATA    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_datak_in,
  input  logic        i_x1_mode,
  output logic        o_sof_out,
  output logic [31:0] o_data_out,
  output logic [3:0]  o_data_valid_out,
  output logic        o_am_det,
  output logic        o_char_err
);

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_AM   = 8'h7C;
  localparam logic [7:0] K_SOF  = 8'hFB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GOT_S,
    S_GOT_A,
    S_GOT_55
  } state_e;

  if (AM_INTERVAL > 254) begin : g_am_interval_range
    $error("AM_INTERVAL must be in 0..254");
  end

  state_e      state_q, state_d;
  state_e      state_cur;
  logic        x1_mode_q;
  logic        mode_chg;
  logic        seq_fail;
  logic        dec_err;
  logic        mon_err;
  logic [7:0]  d0;
  logic        k0;
  logic        am_word;
  logic        idle_word;

  logic        sof_q, sof_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  valid_q, valid_d;
  logic        am_q, am_d;
  logic        err_q, err_d;

  assign d0        = i_data_in[7:0];
  assign k0        = i_datak_in[0];
  assign mode_chg  = (i_x1_mode != x1_mode_q);
  assign am_word   = !i_x1_mode && (i_datak_in == 4'hF) && (i_data_in == {4{K_AM}});
  assign idle_word = !i_x1_mode && (i_datak_in == 4'hF) && (i_data_in == {4{K_IDLE}});

  // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = S_IDLE;
    state_cur = state_q;
    seq_fail  = 1'b0;
    dec_err   = 1'b0;
    sof_d     = 1'b0;
    data_d    = 32'h0;
    valid_d   = 4'h0;
    am_d      = 1'b0;

    if (!i_x1_mode) begin
      if (i_datak_in == 4'h0) begin
        data_d  = i_data_in;
        valid_d = 4'hF;
      end else if (i_datak_in == 4'hF && i_data_in == {4{K_SOF}}) begin
        sof_d   = 1'b1;
        data_d  = SOF_DATA;
        valid_d = 4'hF;
      end else if (am_word) begin
        am_d = 1'b1;
      end else if (!idle_word) begin
        dec_err = 1'b1;
      end
    end else begin
      // A mode switch restarts the sequence from IDLE without flagging an error.
      state_cur = mode_chg ? S_IDLE : state_q;
      state_d   = state_cur;
      unique case (state_cur)
        S_IDLE: begin
          if (!k0) begin
            data_d  = {24'h0, d0};
            valid_d = 4'h1;
          end else if (d0 == K_SOF) begin
            state_d = S_GOT_S;
          end else if (d0 != K_IDLE) begin
            seq_fail = 1'b1;
          end
        end
        S_GOT_S: begin
          if (k0 && d0 == K_AM) state_d = S_GOT_A;
          else                  seq_fail = 1'b1;
        end
        S_GOT_A: begin
          if (!k0 && d0 == 8'h55) state_d = S_GOT_55;
          else                    seq_fail = 1'b1;
        end
        S_GOT_55: begin
          if (!k0 && d0 == 8'h00) begin
            sof_d   = 1'b1;
            data_d  = {24'h0, SOF_DATA[7:0]};
            valid_d = 4'h1;
            state_d = S_IDLE;
          end else begin
            seq_fail = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (seq_fail) begin
        dec_err = 1'b1;
        state_d = (k0 && d0 == K_SOF) ? S_GOT_S : S_IDLE;
      end
      if (mode_chg) begin
        dec_err = 1'b0;
        state_d = S_IDLE;
      end
    end

    err_d = dec_err | mon_err;
  end

`ifdef RX_AM_MON_EN
  localparam logic [8:0] AM_LIMIT = 9'(AM_INTERVAL);

  logic [8:0] am_cnt_q, am_cnt_d;
  logic       am_armed_q, am_armed_d;

  // Cycles since the last |A|; an |I| past the interval means a marker was replaced.
  always_comb begin
    am_armed_d = am_armed_q;
    mon_err    = 1'b0;
    if (am_word)                 am_cnt_d = 9'd0;
    else if (&am_cnt_q)          am_cnt_d = am_cnt_q;
    else                         am_cnt_d = am_cnt_q + 9'd1;

    if (am_word) begin
      am_armed_d = 1'b1;
    end else if (am_armed_q && idle_word && am_cnt_q > AM_LIMIT) begin
      mon_err    = 1'b1;
      am_armed_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      am_cnt_q   <= 9'd0;
      am_armed_q <= 1'b0;
    end else begin
      am_cnt_q   <= am_cnt_d;
      am_armed_q <= am_armed_d;
    end
  end
`else
  assign mon_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      x1_mode_q <= 1'b0;
      sof_q     <= 1'b0;
      data_q    <= 32'h0;
      valid_q   <= 4'h0;
      am_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x1_mode_q <= i_x1_mode;
      sof_q     <= sof_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      am_q      <= am_d;
      err_q     <= err_d;
    end
  end

  assign o_sof_out        = sof_q;
  assign o_data_out       = data_q;
  assign o_data_valid_out = valid_q;
  assign o_am_det         = am_q;
  assign o_char_err       = err_q;

endmodule

// File: tb/tb_rx_char_restore.sv
// Scoreboard bench for rx_char_restore: directed beats push expected output
// events; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_rx_char_restore;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_data_in;
  logic [3:0]  i_datak_in;
  logic        i_x1_mode;
  logic        o_sof_out;
  logic [31:0] o_data_out;
  logic [3:0]  o_data_valid_out;
  logic        o_am_det;
  logic        o_char_err;

  typedef struct packed {
    logic        sof;
    logic [31:0] data;
    logic [3:0]  valid;
    logic        am;
    logic        err;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  rx_char_restore #(
    .AM_INTERVAL(4),
    .SOF_DATA   (32'h0000_0000)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_data_in       (i_data_in),
    .i_datak_in      (i_datak_in),
    .i_x1_mode       (i_x1_mode),
    .o_sof_out       (o_sof_out),
    .o_data_out      (o_data_out),
    .o_data_valid_out(o_data_valid_out),
    .o_am_det        (o_am_det),
    .o_char_err      (o_char_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input ev_t act, input ev_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sof=%0b data=%h valid=%h am=%0b err=%0b, expected sof=%0b data=%h valid=%h am=%0b err=%0b",
               name, act.sof, act.data, act.valid, act.am, act.err,
               exp.sof, exp.data, exp.valid, exp.am, exp.err);
    end
  endtask

  function automatic ev_t cur_out();
    ev_t e;
    e = '{sof: o_sof_out, data: o_data_out, valid: o_data_valid_out,
          am: o_am_det, err: o_char_err};
    return e;
  endfunction

  function automatic void expect_ev(input logic sof, input logic [31:0] data,
                                    input logic [3:0] valid, input logic am,
                                    input logic err);
    ev_t e;
    e = '{sof: sof, data: data, valid: valid, am: am, err: err};
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic [31:0] d, input logic [3:0] k, input logic x1);
    @(negedge i_clk);
    i_data_in  = d;
    i_datak_in = k;
    i_x1_mode  = x1;
  endtask

  // Monitor: any visible output activity must match the oldest expected event.
  always @(negedge i_clk) begin
    if (i_rst_n && (o_sof_out || o_data_valid_out != 4'h0 || o_am_det ||
                    o_char_err || o_data_out != 32'h0)) begin
      if (exp_q.size() == 0) check("unexpected_output", cur_out(), '0);
      else                   check("scoreboard", cur_out(), exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ev_t qlen;
    i_rst_n    = 1'b0;
    i_data_in  = {4{8'hBC}};
    i_datak_in = 4'hF;
    i_x1_mode  = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset_state", cur_out(), '0);
    i_rst_n = 1'b1;

    // x4: idle, SOF, data word.
    step({4{8'hBC}}, 4'hF, 1'b0);
    step({4{8'hFB}}, 4'hF, 1'b0); expect_ev(1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
    step(32'h1122_3344, 4'h0, 1'b0); expect_ev(1'b0, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    // K-looking bytes with K=0 are plain data; unknown K code is an error.
    step({4{8'hFB}}, 4'h0, 1'b0); expect_ev(1'b0, 32'hFBFB_FBFB, 4'hF, 1'b0, 1'b0);
    step({4{8'h1C}}, 4'hF, 1'b0); expect_ev(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);

    // x4: alignment marker, unequal K bytes, mixed K mask.
    step({4{8'h7C}}, 4'hF, 1'b0); expect_ev(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step(32'hBC7C_BCBC, 4'hF, 1'b0); expect_ev(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    step({4{8'h7C}}, 4'h3, 1'b0); expect_ev(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);

    // x1: full SOF sequence with junk on lanes 1-3, then a data byte.
    step(32'hDEAD_BEBC, 4'hF, 1'b1);
    step(32'h1234_56FB, 4'hF, 1'b1);
    step(32'h9999_997C, 4'h1, 1'b1);
    step(32'h7C7C_7C55, 4'hE, 1'b1);
    step(32'hFBFB_FB00, 4'hE, 1'b1); expect_ev(1'b1, 32'h0, 4'h1, 1'b0, 1'b0);
    step(32'hABCD_EFA5, 4'hE, 1'b1); expect_ev(1'b0, 32'h0000_00A5, 4'h1, 1'b0, 1'b0);

    // x1: restarted |S| inside the sequence is flagged but not lost.
    step(32'hFB, 4'h1, 1'b1);
    step(32'h7C, 4'h1, 1'b1);
    step(32'hFB, 4'h1, 1'b1); expect_ev(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    step(32'h7C, 4'h1, 1'b1);
    step(32'h55, 4'h0, 1'b1);
    step(32'h00, 4'h0, 1'b1); expect_ev(1'b1, 32'h0, 4'h1, 1'b0, 1'b0);
    // x1: |A| outside a sequence is illegal.
    step(32'h7C, 4'h1, 1'b1); expect_ev(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);

    // Reset while in GOT_A: the tail comes out as plain bytes.
    step(32'hFB, 4'h1, 1'b1);
    step(32'h7C, 4'h1, 1'b1);
    @(negedge i_clk);
    i_rst_n    = 1'b0;
    i_data_in  = 32'hBC;
    i_datak_in = 4'h1;
    repeat (2) @(negedge i_clk);
    check("reset_mid_sequence", cur_out(), '0);
    i_rst_n = 1'b1;
    step(32'h55, 4'h0, 1'b1); expect_ev(1'b0, 32'h0000_0055, 4'h1, 1'b0, 1'b0);
    step(32'h00, 4'h0, 1'b1); expect_ev(1'b0, 32'h0, 4'h1, 1'b0, 1'b0);

    // Mode toggle while in GOT_A also returns the FSM to IDLE.
    step(32'hFB, 4'h1, 1'b1);
    step(32'h7C, 4'h1, 1'b1);
    step({4{8'hBC}}, 4'hF, 1'b0);
    step(32'hBC, 4'h1, 1'b1);
    step(32'h55, 4'h0, 1'b1); expect_ev(1'b0, 32'h0000_0055, 4'h1, 1'b0, 1'b0);
    step(32'h00, 4'h0, 1'b1); expect_ev(1'b0, 32'h0, 4'h1, 1'b0, 1'b0);

    // Marker interval: |A| then idles; with the monitor, the 6th idle
    // (counter 5 > 4) pulses once and the monitor stays quiet until re-armed.
    step({4{8'hBC}}, 4'hF, 1'b0);
    for (int r = 0; r < 2; r++) begin
      step({4{8'h7C}}, 4'hF, 1'b0); expect_ev(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
        step({4{8'hBC}}, 4'hF, 1'b0);
`ifdef RX_AM_MON_EN
        if (i == 5) expect_ev(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
`endif
      end
    end

    repeat (3) step({4{8'hBC}}, 4'hF, 1'b0);
    @(negedge i_clk);
    qlen = '0;
    qlen.data = 32'(exp_q.size());
    check("missing_outputs", qlen, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
